// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares one 32-bit memory port between the CPU datapath (port 0) and a
// secondary master (port 1). One access is granted at a time. Ties go to the
// port that was not served last. The granted request is latched, and the
// memory strobe is held for LAT cycles. Read data is returned with a one-cycle
// DONE pulse. Every output comes straight from a register.

module mem_port_arbiter #(
    parameter int LAT = 2                       // strobe length in cycles, 1..15
) (
    input  logic        CLK,
    input  logic        RST,                    // asynchronous, active-low
    input  logic        REQ0,
    input  logic        REQ1,
    input  logic        WE0,
    input  logic        WE1,
    input  logic [25:0] ADDR0,
    input  logic [25:0] ADDR1,
    input  logic [31:0] WDATA0,
    input  logic [31:0] WDATA1,
    output logic        GNT0,
    output logic        GNT1,
    output logic        DONE0,
    output logic        DONE1,
    output logic [31:0] RDATA,
    output logic        MEM_READ,
    output logic        MEM_WRITE,
    output logic [25:0] MEM_ADDR,
    output logic [31:0] MEM_WDATA,
    input  logic [31:0] MEM_RDATA
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    // The count starts at LAT-1 so that the strobe spans exactly LAT cycles.
    // With LAT=1 the count is already zero in the first BUSY cycle.
    localparam logic [3:0] CNT_LOAD = 4'(LAT - 1);

    state_t      state_reg, state_next;
    logic [3:0]  cnt_reg, cnt_next;
    logic        last_reg, last_next;       // port served most recently
    logic [1:0]  gnt_reg, gnt_next;
    logic [1:0]  done_reg, done_next;
    logic        mem_read_reg, mem_read_next;
    logic        mem_write_reg, mem_write_next;
    logic [25:0] mem_addr_reg, mem_addr_next;
    logic [31:0] mem_wdata_reg, mem_wdata_next;
    logic [31:0] rdata_reg, rdata_next;

    logic [1:0]  req_vec;
    logic [1:0]  win_vec;                   // one-hot winner, zero if no request
    logic        sel;                       // index of the winning port
    logic        sel_we;
    logic [25:0] sel_addr;
    logic [31:0] sel_wdata;

    assign req_vec = {REQ1, REQ0};

    // A port wins when it is the only requester. It also wins a tie if it
    // was not the port served last time.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_win
            assign win_vec[gi] = req_vec[gi] &
                                 (~req_vec[1 - gi] | (last_reg != 1'(gi)));
        end
    endgenerate

    assign sel       = win_vec[1];
    assign sel_we    = sel ? WE1    : WE0;
    assign sel_addr  = sel ? ADDR1  : ADDR0;
    assign sel_wdata = sel ? WDATA1 : WDATA0;

    // Next-state and next-output logic. Every register keeps its value
    // unless the current state changes it.
    always_comb begin
        state_next     = state_reg;
        cnt_next       = cnt_reg;
        last_next      = last_reg;
        gnt_next       = gnt_reg;
        done_next      = done_reg;
        mem_read_next  = mem_read_reg;
        mem_write_next = mem_write_reg;
        mem_addr_next  = mem_addr_reg;
        mem_wdata_next = mem_wdata_reg;
        rdata_next     = rdata_reg;

        case (state_reg)
            IDLE: begin
                if (|req_vec) begin
                    gnt_next       = win_vec;
                    last_next      = sel;
                    mem_addr_next  = sel_addr;
                    mem_wdata_next = sel_wdata;
                    mem_read_next  = ~sel_we;
                    mem_write_next = sel_we;
                    cnt_next       = CNT_LOAD;
                    state_next     = BUSY;
                end
            end

            BUSY: begin
                if (cnt_reg != 4'd0) begin
                    cnt_next = cnt_reg - 4'd1;
                end else begin
                    // MEM_RDATA is valid in the final strobe cycle.
                    if (mem_read_reg) begin
                        rdata_next = MEM_RDATA;
                    end
                    mem_read_next  = 1'b0;
                    mem_write_next = 1'b0;
                    done_next      = gnt_reg;
                    state_next     = DONE;
                end
            end

            DONE: begin
                // No arbitration happens here. The requester drops REQ
                // during this cycle.
                done_next  = 2'b00;
                gnt_next   = 2'b00;
                state_next = IDLE;
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State and output registers. Reset aborts any access in flight at once.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_reg     <= IDLE;
            cnt_reg       <= 4'd0;
            last_reg      <= 1'b1;
            gnt_reg       <= 2'b00;
            done_reg      <= 2'b00;
            mem_read_reg  <= 1'b0;
            mem_write_reg <= 1'b0;
            mem_addr_reg  <= 26'd0;
            mem_wdata_reg <= 32'd0;
            rdata_reg     <= 32'd0;
        end else begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            last_reg      <= last_next;
            gnt_reg       <= gnt_next;
            done_reg      <= done_next;
            mem_read_reg  <= mem_read_next;
            mem_write_reg <= mem_write_next;
            mem_addr_reg  <= mem_addr_next;
            mem_wdata_reg <= mem_wdata_next;
            rdata_reg     <= rdata_next;
        end
    end

    assign GNT0      = gnt_reg[0];
    assign GNT1      = gnt_reg[1];
    assign DONE0     = done_reg[0];
    assign DONE1     = done_reg[1];
    assign MEM_READ  = mem_read_reg;
    assign MEM_WRITE = mem_write_reg;
    assign MEM_ADDR  = mem_addr_reg;
    assign MEM_WDATA = mem_wdata_reg;
    assign RDATA     = rdata_reg;

endmodule
